// File: rtl/filter_line_pkg.sv
// Shared types and helpers for the filter-safe serial line transmitter.
package filter_line_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Logical idle / stop level of the wire before any output polarity option.
  localparam logic LINE_IDLE = 1'b1;

  // Counter width for a counter that must represent values 0..n-1 (at least 1 bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/filter_line_bit_timer.sv
// Bit-period timer: counts 0..BIT_CYCLES-1 while run is high, ticks on the last count.
module filter_line_bit_timer
  import filter_line_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = 40
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);

  localparam int unsigned CW = cnt_width(BIT_CYCLES);

  logic [CW-1:0] cnt;

  assign tick = run && (cnt == CW'(BIT_CYCLES - 1));

  // Cycle counter: held at zero when idle, wraps at the end of each bit period.
  always_ff @(posedge clk) begin
    if (!rst_n || !run) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/filter_line_tx.sv
// Serial line transmitter whose symbols are held long enough to pass the remote
// 30-cycle debounce filter. Frame: start bit, DATA_W data bits MSB first, stop bit(s).
// Optional build macro FILTER_LINE_INV_EN inverts the line at the output register.
module filter_line_tx
  import filter_line_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned BIT_CYCLES = 40,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              line,
  output logic              busy,
  output logic              tx_done
);

  localparam int unsigned BW = cnt_width(DATA_W + 1);

`ifdef FILTER_LINE_INV_EN
  localparam logic LINE_POL = 1'b1;
`else
  localparam logic LINE_POL = 1'b0;
`endif

  if (BIT_CYCLES < 33) begin : g_bit_cycles_chk
    $error("filter_line_tx: BIT_CYCLES must be >= 33 to clear the remote filter window");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_bits_chk
    $error("filter_line_tx: STOP_BITS must be 1 or 2");
  end

  state_t            state;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_nxt;
  logic [BW-1:0]     bit_cnt;
  logic              run;
  logic              tick;

  assign run       = (state != IDLE);
  assign shift_nxt = shift_q << 1;

  filter_line_bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (run),
    .tick (tick)
  );

  // Frame sequencer; line is driven from this register so it can only move on a bit tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      line     <= LINE_IDLE ^ LINE_POL;
      tx_ready <= 1'b0;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
      bit_cnt  <= '0;
      shift_q  <= '0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          tx_ready <= 1'b1;
          busy     <= 1'b0;
          line     <= LINE_IDLE ^ LINE_POL;
          if (tx_valid && tx_ready) begin
            shift_q  <= tx_data;
            bit_cnt  <= '0;
            state    <= START;
            line     <= (!LINE_IDLE) ^ LINE_POL;
            busy     <= 1'b1;
            tx_ready <= 1'b0;
          end
        end
        START: begin
          if (tick) begin
            state <= DATA;
            line  <= shift_q[DATA_W-1] ^ LINE_POL;
          end
        end
        DATA: begin
          if (tick) begin
            shift_q <= shift_nxt;
            if (bit_cnt == BW'(DATA_W - 1)) begin
              state   <= STOP;
              bit_cnt <= '0;
              line    <= LINE_IDLE ^ LINE_POL;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              line    <= shift_nxt[DATA_W-1] ^ LINE_POL;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (bit_cnt == BW'(STOP_BITS - 1)) begin
              state    <= IDLE;
              bit_cnt  <= '0;
              tx_done  <= 1'b1;
              busy     <= 1'b0;
              tx_ready <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
